// File: rtl/adc_sample_capture_writer_if.sv
// ADC capture writer bundle: sample input, control,
// RAM port-2 write side and capture status.
interface adc_sample_capture_writer_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 13,
  parameter int DECIM_W = 8
) ();
  logic [DATA_W-1:0]  sample_data;
  logic               sample_valid;
  logic               start;
  logic               abort;
  logic               trig_mode;
  logic [DATA_W-1:0]  trig_level;
  logic [DECIM_W-1:0] decim;
  logic [ADDR_W-1:0]  address2;
  logic [DATA_W-1:0]  writedata2;
  logic [1:0]         byteenable2;
  logic               chipselect2;
  logic               write2;
  logic               clken2;
  logic               busy;
  logic               done;
  logic               overrun;
  logic [ADDR_W-1:0]  word_count;

  modport slave (
    input  sample_data, sample_valid,
    input  start, abort,
    input  trig_mode, trig_level, decim,
    output address2, writedata2,
    output byteenable2, chipselect2,
    output write2, clken2,
    output busy, done, overrun, word_count
  );

  modport master (
    output sample_data, sample_valid,
    output start, abort,
    output trig_mode, trig_level, decim,
    input  address2, writedata2,
    input  byteenable2, chipselect2,
    input  write2, clken2,
    input  busy, done, overrun, word_count
  );
endinterface

// File: rtl/adc_sample_capture_writer.sv
// Triggered ADC block capture into RAM port 2,
// with decimation, abort and done/overrun status.
module adc_sample_capture_writer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 13,
  parameter int DEPTH   = 5000,
  parameter int DECIM_W = 8
) (
  input logic clk,
  input logic reset_n,
  adc_sample_capture_writer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_waddr;
  logic [ADDR_W-1:0]   r_wcount;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write;
  logic                r_busy;
  logic                r_done;
  logic                r_overrun;
  logic                r_vld_d;
  logic                r_prev_vld;
  logic signed [DATA_W-1:0] r_prev;
  logic [DECIM_W-1:0]  r_decim;
  logic [DECIM_W-1:0]  r_dcnt;

  logic signed [DATA_W-1:0] w_data;
  logic signed [DATA_W-1:0] w_level;
  logic                w_cross;
  logic                w_trig;
  logic                w_keep;
  logic                w_wr;
  logic                w_last;
  logic [DECIM_W-1:0]  w_dcnt_nxt;

  assign w_data  = bus.sample_data;
  assign w_level = bus.trig_level;

  // prev is only meaningful once a sample has been seen since arming
  assign w_cross = r_prev_vld
                && (r_prev < w_level)
                && (w_level <= w_data);

  assign w_trig = bus.sample_valid
               && (!bus.trig_mode || w_cross);

  assign w_keep = bus.sample_valid
               && (r_dcnt == '0);

  assign w_dcnt_nxt = (r_dcnt == r_decim)
                    ? '0 : r_dcnt + 1'b1;

  assign w_last = (r_wcount == ADDR_W'(DEPTH - 1));

  // abort suppresses any write decided on the same edge
  assign w_wr = !bus.abort
             && (((r_state == S_ARMED) && w_trig)
              || ((r_state == S_CAPTURE) && w_keep));

  assign bus.address2    = r_addr;
  assign bus.writedata2  = r_wdata;
  assign bus.byteenable2 = 2'b11;
  assign bus.chipselect2 = r_write;
  assign bus.write2      = r_write;
  assign bus.clken2      = 1'b1;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.overrun     = r_overrun;
  assign bus.word_count  = r_wcount;

  // capture FSM with registered RAM strobe and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_waddr    <= '0;
      r_wcount   <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_vld_d    <= 1'b0;
      r_prev_vld <= 1'b0;
      r_prev     <= '0;
      r_decim    <= '0;
      r_dcnt     <= '0;
    end else begin
      r_write <= 1'b0;
      r_vld_d <= bus.sample_valid
              && (r_state == S_CAPTURE);
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              r_state    <= S_ARMED;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_overrun  <= 1'b0;
              r_wcount   <= '0;
              r_waddr    <= '0;
              r_addr     <= '0;
              r_dcnt     <= '0;
              r_prev_vld <= 1'b0;
              r_decim    <= bus.decim;
            end
          end
          S_ARMED: begin
            if (w_trig) begin
              r_state <= S_CAPTURE;
              r_dcnt  <= (r_decim == '0)
                       ? '0 : DECIM_W'(1);
            end else if (bus.sample_valid) begin
              r_prev     <= w_data;
              r_prev_vld <= 1'b1;
            end
          end
          S_CAPTURE: begin
            if (bus.sample_valid) begin
              r_dcnt <= w_dcnt_nxt;
              if (r_vld_d)
                r_overrun <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
        if (w_wr) begin
          r_write  <= 1'b1;
          r_addr   <= r_waddr;
          r_wdata  <= bus.sample_data;
          r_waddr  <= r_waddr + 1'b1;
          r_wcount <= r_wcount + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_capture_writer.sv
// Directed bench for adc_sample_capture_writer:
// vector table plus full-depth and reset sequences.
module tb_adc_sample_capture_writer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  adc_sample_capture_writer_if bus ();

  adc_sample_capture_writer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, ab, v;
    logic [15:0] d;
    logic        md;
    logic [15:0] lv;
    logic [7:0]  dc;
    logic        w;
    logic [12:0] a;
    logic [15:0] wd;
    logic [12:0] wc;
    logic        bz, dn, ov;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input int st, input int ab, input int v,
    input int d, input int md, input int lv,
    input int dc, input int w, input int a,
    input int wd, input int wc, input int bz,
    input int dn, input int ov);
    vec_t r;
    r.st = st[0]; r.ab = ab[0]; r.v = v[0];
    r.d = 16'(d); r.md = md[0];
    r.lv = 16'(lv); r.dc = 8'(dc);
    r.w = w[0]; r.a = 13'(a);
    r.wd = 16'(wd); r.wc = 13'(wc);
    r.bz = bz[0]; r.dn = dn[0]; r.ov = ov[0];
    tbl.push_back(r);
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic st,
                       input logic ab,
                       input logic v,
                       input logic [15:0] d);
    bus.start = st;
    bus.abort = ab;
    bus.sample_valid = v;
    bus.sample_data = d;
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.write2, bus.chipselect2,
                bus.address2, bus.writedata2,
                bus.word_count, bus.busy,
                bus.done, bus.overrun});
  endfunction

  initial begin
    logic [63:0] e;
    bus.trig_mode = 1'b0;
    bus.trig_level = '0;
    bus.decim = '0;
    drive(0, 0, 0, 16'd0);

    // start+abort from IDLE
    add(1,1,0,0, 0,0,0, 0,0,0,0, 0,0,0);
    // level trigger at 100
    add(1,0,0,0, 1,100,0, 0,0,0,0, 1,0,0);
    add(0,0,1,-50, 1,100,0, 0,0,0,0, 1,0,0);
    add(0,0,1,50, 1,100,0, 0,0,0,0, 1,0,0);
    add(0,0,1,99, 1,100,0, 0,0,0,0, 1,0,0);
    add(0,0,1,100, 1,100,0, 1,0,100,1, 1,0,0);
    add(0,0,0,0, 1,100,0, 0,0,100,1, 1,0,0);
    add(0,0,1,101, 1,100,0, 1,1,101,2, 1,0,0);
    add(0,1,0,0, 1,100,0, 0,1,101,2, 0,0,0);
    // first sample after arm never triggers
    add(1,0,0,0, 1,100,0, 0,0,101,0, 1,0,0);
    add(0,0,1,200, 1,100,0, 0,0,101,0, 1,0,0);
    add(0,0,1,50, 1,100,0, 0,0,101,0, 1,0,0);
    add(0,0,1,150, 1,100,0, 1,0,150,1, 1,0,0);
    add(0,1,0,0, 1,100,0, 0,0,150,1, 0,0,0);
    // decim=3 latched at start, ramp 0..15
    add(1,0,0,0, 0,0,3, 0,0,150,0, 1,0,0);
    add(0,0,1,0, 0,0,0, 1,0,0,1, 1,0,0);
    for (int i = 1; i < 16; i++) begin
      if (i % 4 == 0)
        add(0,0,1,i, 0,0,0, 1,i/4,i,i/4+1,
            1,0,(i>1));
      else
        add(0,0,1,i, 0,0,0, 0,i/4,(i/4)*4,
            i/4+1, 1,0,(i>1));
    end
    add(0,1,0,0, 0,0,0, 0,3,12,4, 0,0,1);
    // abort collides with kept sample at word 10
    add(1,0,0,0, 0,0,0, 0,0,12,0, 1,0,0);
    for (int i = 0; i < 10; i++)
      add(0,0,1,1000+i, 0,0,0, 1,i,1000+i,i+1,
          1,0,(i>1));
    add(0,1,1,2000, 0,0,0, 0,9,1009,10, 0,0,1);
    add(0,0,0,0, 0,0,0, 0,9,1009,10, 0,0,1);
    // start during CAPTURE is ignored
    add(1,0,0,0, 0,0,0, 0,0,1009,0, 1,0,0);
    add(0,0,1,7, 0,0,0, 1,0,7,1, 1,0,0);
    add(1,0,1,8, 0,0,0, 1,1,8,2, 1,0,0);
    add(0,0,0,0, 0,0,0, 0,1,8,2, 1,0,0);
    add(0,1,0,0, 0,0,0, 0,1,8,2, 0,0,0);

    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_outs", outs(), 64'd0);
    check("reset_consts",
          64'({bus.byteenable2, bus.clken2}),
          64'(3'b111));
    @(negedge clk);

    foreach (tbl[k]) begin
      bus.trig_mode  = tbl[k].md;
      bus.trig_level = tbl[k].lv;
      bus.decim      = tbl[k].dc;
      drive(tbl[k].st, tbl[k].ab,
            tbl[k].v, tbl[k].d);
      step();
      e = 64'({tbl[k].w, tbl[k].w, tbl[k].a,
               tbl[k].wd, tbl[k].wc, tbl[k].bz,
               tbl[k].dn, tbl[k].ov});
      check($sformatf("vec%0d", k), outs(), e);
    end
    drive(0, 0, 0, 16'd0);

    // full-depth ramp capture
    bus.trig_mode = 1'b0;
    bus.decim = '0;
    drive(1, 0, 0, 16'd0);
    step();
    for (int i = 0; i < 5000; i++) begin
      drive(0, 0, 1, 16'(i));
      step();
      check("ramp_wr",
            64'({bus.write2, bus.chipselect2,
                 bus.address2, bus.writedata2,
                 bus.word_count, bus.done}),
            64'({2'b11, 13'(i), 16'(i),
                 13'(i + 1), (i == 4999)}));
      drive(0, 0, 0, 16'd0);
      step();
      check("ramp_gap", 64'(bus.write2), 64'd0);
    end
    drive(0, 0, 1, 16'd5000);
    step();
    check("ramp_extra", outs(),
          64'({2'b00, 13'd4999, 16'd4999,
               13'd5000, 1'b0, 1'b1, 1'b0}));
    drive(0, 0, 0, 16'd0);
    step();

    // reset pulse mid-capture
    drive(1, 0, 0, 16'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 16'(300 + i));
      step();
      drive(0, 0, 0, 16'd0);
      step();
    end
    check("mid_wc", 64'(bus.word_count), 64'd3);
    reset_n = 1'b0;
    #1;
    check("mid_reset", outs(), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 0, 16'd0);
    step();
    drive(0, 0, 1, 16'd77);
    step();
    check("post_reset", outs(),
          64'({2'b11, 13'd0, 16'd77, 13'd1,
               1'b1, 1'b0, 1'b0}));
    drive(0, 0, 0, 16'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
